// File: rtl/sort_seq_ctrl.sv
// sort_seq_ctrl: time-shares one sort_stage across M passes and streams the extracted maxima out in descending order.
// Define SORT_SEQ_ORDER_CHK_EN to build the sticky descending-order checker behind o_order_err.
module sort_seq_ctrl #(
    parameter int M         = 8,
    parameter int N         = 16,
    parameter int STAGE_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_flush,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [M-1:0][N-1:0] s_data,
    output logic                o_stg_enable,
    output logic [M-1:0][N-1:0] o_stg_chi,
    input  logic [N-1:0]        i_stg_y_q,
    input  logic [M-1:0][N-1:0] i_stg_chi,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [N-1:0]        m_data,
    output logic                m_last,
    output logic                o_busy,
    output logic                o_order_err
);
    localparam int PW = (M > 1) ? $clog2(M) : 1;
    localparam int LW = $clog2(STAGE_LAT + 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(M - 1);
    localparam logic [LW-1:0] LAT_DONE  = LW'(STAGE_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

    state_t              state_q, state_d;
    logic [M-1:0][N-1:0] chi_q, chi_d;
    logic [N-1:0]        out_q, out_d;
    logic [PW-1:0]       pass_cnt_q, pass_cnt_d;
    logic [LW-1:0]       lat_cnt_q, lat_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            chi_q      <= '0;
            out_q      <= '0;
            pass_cnt_q <= '0;
            lat_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            chi_q      <= chi_d;
            out_q      <= out_d;
            pass_cnt_q <= pass_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    // Flush wins over everything and leaves the datapath registers untouched.
    always_comb begin
        state_d    = state_q;
        chi_d      = chi_q;
        out_d      = out_q;
        pass_cnt_d = pass_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        if (i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        chi_d      = s_data;
                        pass_cnt_d = '0;
                        state_d    = ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt_d = LW'(1);
                    state_d   = WAIT;
                end
                WAIT: begin
                    if (lat_cnt_q == LAT_DONE) begin
                        out_d   = i_stg_y_q;
                        chi_d   = i_stg_chi;
                        state_d = EMIT;
                    end else begin
                        lat_cnt_d = lat_cnt_q + LW'(1);
                    end
                end
                EMIT: begin
                    if (m_ready) begin
                        if (pass_cnt_q == LAST_PASS) begin
                            state_d = IDLE;
                        end else begin
                            pass_cnt_d = pass_cnt_q + PW'(1);
                            state_d    = ISSUE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign s_ready      = (state_q == IDLE) && !rst;
    assign o_stg_enable = (state_q == ISSUE) && !i_flush;
    assign o_stg_chi    = chi_q;
    assign m_valid      = (state_q == EMIT);
    assign m_data       = out_q;
    assign m_last       = (state_q == EMIT) && (pass_cnt_q == LAST_PASS);
    assign o_busy       = (state_q != IDLE);

`ifdef SORT_SEQ_ORDER_CHK_EN
    logic [N-1:0] prev_q;
    logic         order_err_q;
    logic         accept;
    logic         handshake;

    assign accept    = (state_q == IDLE) && s_valid && !i_flush;
    assign handshake = (state_q == EMIT) && m_ready && !i_flush;

    // A later element larger than the one before it means the stage broke descending order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q      <= '0;
            order_err_q <= 1'b0;
        end else if (accept) begin
            prev_q <= '0;
        end else if (handshake) begin
            if ((pass_cnt_q != '0) && (out_q > prev_q)) begin
                order_err_q <= 1'b1;
            end
            prev_q <= out_q;
        end
    end

    assign o_order_err = order_err_q;
`else
    assign o_order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Self-checking bench for sort_seq_ctrl: behavioural max-extract stage, sorted-queue reference, randomized vectors.
module tb_sort_seq_ctrl;
    localparam int M = 4;
    localparam int N = 8;
    localparam int L = 2;
`ifdef SORT_SEQ_ORDER_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                i_flush;
    logic                s_valid;
    logic                s_ready;
    logic [M-1:0][N-1:0] s_data;
    logic                o_stg_enable;
    logic [M-1:0][N-1:0] o_stg_chi;
    logic [N-1:0]        i_stg_y_q;
    logic [M-1:0][N-1:0] i_stg_chi;
    logic                m_valid;
    logic                m_ready;
    logic [N-1:0]        m_data;
    logic                m_last;
    logic                o_busy;
    logic                o_order_err;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sort_seq_ctrl #(.M(M), .N(N), .STAGE_LAT(L)) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .o_stg_enable(o_stg_enable), .o_stg_chi(o_stg_chi),
        .i_stg_y_q(i_stg_y_q), .i_stg_chi(i_stg_chi),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .o_busy(o_busy), .o_order_err(o_order_err)
    );

    // Stage model: max of the vector, first occurrence of that max zeroed, result valid L cycles after enable.
    function automatic logic [N-1:0] vmax(input logic [M-1:0][N-1:0] c);
        logic [N-1:0] mx;
        mx = '0;
        for (int i = 0; i < M; i++) if (c[i] > mx) mx = c[i];
        return mx;
    endfunction

    function automatic logic [M-1:0][N-1:0] vrem(input logic [M-1:0][N-1:0] c);
        logic [M-1:0][N-1:0] r;
        logic [N-1:0]        mx;
        logic                done;
        r = c;
        mx = vmax(c);
        done = 1'b0;
        for (int i = 0; i < M; i++) begin
            if (!done && c[i] == mx) begin
                r[i] = '0;
                done = 1'b1;
            end
        end
        return r;
    endfunction

    int                  en_cnt = 0;
    int                  fault_base;
    bit                  fault_mode;
    logic [N-1:0]        p1_y = '0, p2_y = '0;
    logic [M-1:0][N-1:0] p1_chi = '0, p2_chi = '0;

    always @(posedge clk) begin
        if (o_stg_enable) begin
            en_cnt <= en_cnt + 1;
            if (fault_mode) begin
                p1_y   <= (en_cnt == fault_base) ? 8'd2 : 8'd8;
                p1_chi <= o_stg_chi;
            end else begin
                p1_y   <= vmax(o_stg_chi);
                p1_chi <= vrem(o_stg_chi);
            end
        end
        p2_y   <= p1_y;
        p2_chi <= p1_chi;
    end
    assign i_stg_y_q = p2_y;
    assign i_stg_chi = p2_chi;

    // Results collected by run_vec for the calling test to check.
    logic [N-1:0] got_q[$];
    bit           last_q[$];
    bit           err_q[$];
    int           busy_cyc, en_pulses, stall_bad;
    logic [N-1:0] stall_held;
    bit           drv_timeout;

    task automatic run_vec(input logic [M-1:0][N-1:0] v, input int stall_k, input int stall_n);
        int n, k, stall_left, en0;
        bit pend;
        got_q.delete(); last_q.delete(); err_q.delete();
        busy_cyc = 0; stall_bad = 0; drv_timeout = 0; stall_held = '0;
        @(negedge clk);
        s_data = v; s_valid = 1'b1; m_ready = 1'b1;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) drv_timeout = 1;
        en0 = en_cnt;
        @(negedge clk);
        s_valid = 1'b0;
        k = 0; stall_left = stall_n; pend = 0;
        for (int c = 0; c < 300; c++) begin
            if (pend) begin
                err_q.push_back(o_order_err);
                pend = 0;
            end
            if (!o_busy) break;
            busy_cyc++;
            if (m_valid && k == stall_k && stall_left > 0) begin
                if (stall_left == stall_n) stall_held = m_data;
                else if (m_data !== stall_held) stall_bad++;
                if (o_stg_enable) stall_bad++;
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = 1'b1;
                if (m_valid) begin
                    if (k == stall_k && stall_n > 0 && m_data !== stall_held) stall_bad++;
                    got_q.push_back(m_data);
                    last_q.push_back(m_last);
                    k++;
                    pend = 1;
                end
            end
            @(negedge clk);
        end
        if (o_busy) drv_timeout = 1;
        en_pulses = en_cnt - en0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        tests_run++;
        if ({s_ready, o_stg_enable, m_valid, m_last, o_busy, o_order_err} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b required 000000", {s_ready, o_stg_enable, m_valid, m_last, o_busy, o_order_err});
        end
        tests_run++;
        if (m_data !== '0 || o_stg_chi !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: m_data=%h chi=%h required zero", m_data, o_stg_chi);
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_sready_held: got %b required 0", s_ready);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (s_ready !== 1'b1 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: s_ready=%b busy=%b required 1/0", s_ready, o_busy);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_sort_vectors();
        logic [M-1:0][N-1:0] v;
        logic [N-1:0]        ref_q[$];
        logic [N-1:0]        act;
        logic                act_l;
        for (int t = 0; t < 7; t++) begin
            if (t == 0)      v = {8'd7, 8'd1, 8'd9, 8'd3};
            else if (t == 1) v = {8'd5, 8'd5, 8'd5, 8'd5};
            else for (int i = 0; i < M; i++) v[i] = N'($urandom_range(0, 255));
            run_vec(v, -1, 0);
            ref_q.delete();
            for (int i = 0; i < M; i++) ref_q.push_back(v[i]);
            ref_q.rsort();
            $display("[TB] vector %0d in=%h out=%p busy=%0d enables=%0d", t, v, got_q, busy_cyc, en_pulses);
            tests_run++;
            if (drv_timeout || got_q.size() != M) begin
                tests_failed++;
                $display("FAIL vec_count vec%0d: got %0d elements timeout=%0d required %0d", t, got_q.size(), drv_timeout, M);
            end
            for (int i = 0; i < M; i++) begin
                act   = (i < got_q.size()) ? got_q[i] : 'x;
                act_l = (i < last_q.size()) ? last_q[i] : 1'bx;
                tests_run++;
                if (act !== ref_q[i]) begin
                    tests_failed++;
                    $display("FAIL vec_elem vec%0d[%0d]: got %0d required %0d", t, i, act, ref_q[i]);
                end
                tests_run++;
                if (act_l !== (i == M - 1)) begin
                    tests_failed++;
                    $display("FAIL vec_last vec%0d[%0d]: got %b required %b", t, i, act_l, (i == M - 1));
                end
            end
            tests_run++;
            if (en_pulses != M) begin
                tests_failed++;
                $display("FAIL vec_enables vec%0d: got %0d required %0d", t, en_pulses, M);
            end
            tests_run++;
            if (busy_cyc != M * (L + 2)) begin
                tests_failed++;
                $display("FAIL vec_cycles vec%0d: got %0d required %0d", t, busy_cyc, M * (L + 2));
            end
            tests_run++;
            if (o_order_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL vec_order_err vec%0d: got %b required 0", t, o_order_err);
            end
        end
    endtask

    task automatic test_stall();
        logic [N-1:0] exp_q[$];
        logic [N-1:0] act;
        exp_q = '{8'd9, 8'd7, 8'd3, 8'd1};
        run_vec({8'd7, 8'd1, 8'd9, 8'd3}, 1, 5);
        $display("[TB] stall vector out=%p held=%0d busy=%0d", got_q, stall_held, busy_cyc);
        for (int i = 0; i < M; i++) begin
            act = (i < got_q.size()) ? got_q[i] : 'x;
            tests_run++;
            if (act !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL stall_elem[%0d]: got %0d required %0d", i, act, exp_q[i]);
            end
        end
        tests_run++;
        if (stall_held !== 8'd7 || stall_bad != 0) begin
            tests_failed++;
            $display("FAIL stall_hold: held %0d violations %0d required 7/0", stall_held, stall_bad);
        end
        tests_run++;
        if (en_pulses != M || busy_cyc != M * (L + 2) + 5 || drv_timeout) begin
            tests_failed++;
            $display("FAIL stall_timing: enables %0d busy %0d required %0d/%0d", en_pulses, busy_cyc, M, M * (L + 2) + 5);
        end
    endtask

    task automatic test_flush();
        int           n;
        logic [N-1:0] first;
        logic [N-1:0] exp_q[$];
        logic [N-1:0] act;
        @(negedge clk);
        s_data = {8'd7, 8'd1, 8'd9, 8'd3}; s_valid = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        first = m_data;
        @(negedge clk);
        @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        tests_run++;
        if (m_valid !== 1'b0 || o_busy !== 1'b0 || s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_idle: m_valid=%b busy=%b s_ready=%b required 0/0/1", m_valid, o_busy, s_ready);
        end
        tests_run++;
        if (first !== 8'd9 || m_data !== 8'd9) begin
            tests_failed++;
            $display("FAIL flush_data: first %0d now %0d required 9/9", first, m_data);
        end
        exp_q = '{8'd8, 8'd6, 8'd4, 8'd2};
        run_vec({8'd8, 8'd6, 8'd4, 8'd2}, -1, 0);
        $display("[TB] post-flush vector out=%p", got_q);
        for (int i = 0; i < M; i++) begin
            act = (i < got_q.size()) ? got_q[i] : 'x;
            tests_run++;
            if (act !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL flush_next[%0d]: got %0d required %0d", i, act, exp_q[i]);
            end
        end
    endtask

    task automatic test_rst_mid();
        int n, bad;
        m_ready = 1'b0;
        @(negedge clk);
        s_data = {8'd7, 8'd1, 8'd9, 8'd3}; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (m_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_emit: m_valid %b required 1", m_valid);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({s_ready, o_stg_enable, m_valid, m_last, o_busy} !== 5'b0 || m_data !== '0 || o_stg_chi !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: ctrl %b data %h chi %h required zero", {s_ready, o_stg_enable, m_valid, m_last, o_busy}, m_data, o_stg_chi);
        end
        @(negedge clk);
        rst = 1'b0; m_ready = 1'b1;
        #1;
        tests_run++;
        if (s_ready !== 1'b1 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_release: s_ready %b busy %b required 1/0", s_ready, o_busy);
        end
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m_valid || o_stg_enable) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL rst_mid_residual: got %0d active cycles required 0", bad);
        end
        $display("[TB] mid-sort reset checked");
    endtask

    task automatic test_order_flag();
        logic [N-1:0] a0, a1;
        bit           e0, e1;
        logic [M-1:0][N-1:0] v;
        fault_base = en_cnt;
        fault_mode = 1'b1;
        run_vec({8'd1, 8'd1, 8'd1, 8'd1}, -1, 0);
        fault_mode = 1'b0;
        a0 = (got_q.size() > 0) ? got_q[0] : 'x;
        a1 = (got_q.size() > 1) ? got_q[1] : 'x;
        e0 = (err_q.size() > 0) ? err_q[0] : 1'b1;
        e1 = (err_q.size() > 1) ? err_q[1] : !CHK;
        $display("[TB] fault vector out=%p err=%p", got_q, err_q);
        tests_run++;
        if (a0 !== 8'd2 || a1 !== 8'd8) begin
            tests_failed++;
            $display("FAIL order_data: got %0d,%0d required 2,8", a0, a1);
        end
        tests_run++;
        if (e0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL order_first: got %b required 0", e0);
        end
        tests_run++;
        if (e1 !== CHK) begin
            tests_failed++;
            $display("FAIL order_second: got %b required %b", e1, CHK);
        end
        for (int i = 0; i < M; i++) v[i] = N'($urandom_range(0, 255));
        run_vec(v, -1, 0);
        $display("[TB] after-fault vector in=%h out=%p err=%b", v, got_q, o_order_err);
        tests_run++;
        if (o_order_err !== CHK || got_q.size() != M) begin
            tests_failed++;
            $display("FAIL order_sticky: err %b count %0d required %b/%0d", o_order_err, got_q.size(), CHK, M);
        end
    endtask

    initial begin
        rst = 1'b0; i_flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        fault_mode = 1'b0; fault_base = 0;
        test_reset();
        test_sort_vectors();
        test_stall();
        test_flush();
        test_rst_mid();
        test_order_flag();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
